mvm_seq: RTL

Downstream execution stage of the accelerator's command interface. It receives the initiate pulse plus the latched size, W, X and R base addresses from the command decoder. It fetches W[i] and X[i] over a single-outstanding memory port and accumulates the dot product R = Σ W[i]·X[i]. It then writes R to addr R and pulses done.

---
 rtl/mvm_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mvm_seq.sv
// Sequential dot-product engine: fetches W[i], X[i] over one memory port and writes R.
// Optional busy-cycle counter is built when MVM_SEQ_PERF_EN is defined.
module mvm_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [15:0]       size_i,
  input  logic [ADDR_W-1:0] addr_w_i,
  input  logic [ADDR_W-1:0] addr_x_i,
  input  logic [ADDR_W-1:0] addr_r_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_cmd_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  output logic [TAG_W-1:0]  mem_req_tag_o,
  input  logic              mem_resp_valid_i,
  input  logic [TAG_W-1:0]  mem_resp_tag_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic [31:0]       cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_W, S_WAIT_W, S_REQ_X,
    S_WAIT_X, S_WRITE, S_WAIT_WACK, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
  localparam logic [TAG_W-1:0]  TAG_WR = TAG_W'(0);
  localparam logic [TAG_W-1:0]  TAG_XR = TAG_W'(1);
  localparam logic [TAG_W-1:0]  TAG_RW = TAG_W'(2);

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_n;
  logic [15:0]       r_idx;
  logic [ADDR_W-1:0] r_ptr_w;
  logic [ADDR_W-1:0] r_ptr_x;
  logic [ADDR_W-1:0] r_addr_r;
  logic [DATA_W-1:0] r_w;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_result;

  logic              w_start;
  logic              w_resp_w;
  logic              w_resp_x;
  logic              w_resp_r;
  logic              w_last;
  logic [DATA_W-1:0] w_prod;

  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_resp_w = mem_resp_valid_i && (mem_resp_tag_i == TAG_WR);
  assign w_resp_x = mem_resp_valid_i && (mem_resp_tag_i == TAG_XR);
  assign w_resp_r = mem_resp_valid_i && (mem_resp_tag_i == TAG_RW);
  assign w_last   = ({1'b0, r_idx} + 17'd1) == {1'b0, r_n};
  assign w_prod   = r_w * mem_resp_data_i;
  assign result_o = r_result;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    busy_o          = (r_state != S_IDLE);
    done_o          = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_cmd_o   = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    mem_req_tag_o   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i)
          w_next = (size_i == 16'd0) ? S_WRITE : S_REQ_W;
      end
      S_REQ_W: begin
        mem_req_valid_o = 1'b1;
        mem_req_tag_o   = TAG_WR;
        mem_req_addr_o  = r_ptr_w;
        if (mem_req_ready_i) w_next = S_WAIT_W;
      end
      S_WAIT_W: if (w_resp_w) w_next = S_REQ_X;
      S_REQ_X: begin
        mem_req_valid_o = 1'b1;
        mem_req_tag_o   = TAG_XR;
        mem_req_addr_o  = r_ptr_x;
        if (mem_req_ready_i) w_next = S_WAIT_X;
      end
      S_WAIT_X: begin
        if (w_resp_x) w_next = w_last ? S_WRITE : S_REQ_W;
      end
      S_WRITE: begin
        mem_req_valid_o = 1'b1;
        mem_req_cmd_o   = 1'b1;
        mem_req_tag_o   = TAG_RW;
        mem_req_addr_o  = r_addr_r;
        mem_req_data_o  = r_acc;
        if (mem_req_ready_i) w_next = S_WAIT_WACK;
      end
      S_WAIT_WACK: if (w_resp_r) w_next = S_DONE;
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n      <= '0;
      r_idx    <= '0;
      r_ptr_w  <= '0;
      r_ptr_x  <= '0;
      r_addr_r <= '0;
      r_w      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (w_start) begin
        r_n      <= size_i;
        r_ptr_w  <= addr_w_i;
        r_ptr_x  <= addr_x_i;
        r_addr_r <= addr_r_i;
        r_acc    <= '0;
        r_idx    <= '0;
      end
      if (r_state == S_WAIT_W && w_resp_w)
        r_w <= mem_resp_data_i;
      // Accumulator wraps modulo 2^DATA_W by design.
      if (r_state == S_WAIT_X && w_resp_x) begin
        r_acc   <= r_acc + w_prod;
        r_ptr_w <= r_ptr_w + STRIDE;
        r_ptr_x <= r_ptr_x + STRIDE;
        r_idx   <= r_idx + 16'd1;
      end
      if (r_state == S_DONE)
        r_result <= r_acc;
    end
  end

`ifdef MVM_SEQ_PERF_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (reset)
      r_cycles <= '0;
    else if (w_start)
      r_cycles <= '0;
    else if (r_state != S_IDLE)
      r_cycles <= r_cycles + 32'd1;
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = '0;
`endif

endmodule
